// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, range limit and the add-3 correction constants.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] NIBBLE_ADJ_TH = 4'd5;
  localparam logic [3:0] NIBBLE_ADJ    = 4'd3;

  // Largest value representable with the given number of decimal digits.
  function automatic longint unsigned bcd_max(input int digits);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

  localparam longint unsigned BCD_MAX = bcd_max(4);

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One BCD digit of the double-dabble correction: adds 3 to digits 5..9
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= NIBBLE_ADJ_TH) begin
      q = d + NIBBLE_ADJ;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter, one shift per clock,
// with start/busy/done handshake and a result held stable between conversions.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned LIMIT = bcd_max(DIGITS);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q;
  logic [SR_W-1:0]   sr_pre;
  logic [BCD_W-1:0]  adj_bcd;
  logic [CNT_W-1:0]  cnt_q;
  logic              over_q;
  logic              load;
  logic              shift_en;
  logic              finish;

  function automatic logic over_range(input logic [BIN_W-1:0] v);
    return 64'(v) > LIMIT;
  endfunction

  // Correction touches only the BCD field; the binary field passes through.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (sr_q[BIN_W + 4*g +: 4]),
      .q (adj_bcd[4*g +: 4])
    );
  end

  assign sr_pre = {adj_bcd, sr_q[BIN_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      over_q <= 1'b0;
    end else if (load) begin
      sr_q   <= {{BCD_W{1'b0}}, bin_in};
      cnt_q  <= CNT_W'(BIN_W);
      over_q <= over_range(bin_in);
    end else if (shift_en) begin
      sr_q   <= sr_pre << 1;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Visible outputs move only on the done edge so a display never sees partial digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        bcd_out <= over_q ? ALL_NINES : sr_q[SR_W-1 -: BCD_W];
        ovf     <= over_q;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, random values against
// a decimal-arithmetic model, and hand-written handshake/reset sequences.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  int total;
  int bad;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    if (v > 9999) return 16'h9999;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Starts one conversion, checks handshake timing and result hold, returns result.
  task automatic run_conv(input logic [13:0] v, output logic [15:0] res, output logic o);
    int n, busy_n;
    logic [15:0] prev;
    bit held, seen;
    @(negedge clk);
    prev   = bcd_out;
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom);
    n = 1; busy_n = 0; held = 1'b1; seen = 1'b0;
    while (n < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (bcd_out !== prev) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'd16);
    chk("busy_cycles", 32'(busy_n), 32'd15);
    chk("busy_with_done", 32'(busy), 32'd0);
    chk("result_held", 32'(held), 32'd1);
    res = bcd_out;
    o   = ovf;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("result_stable", 32'(bcd_out), 32'(res));
  endtask

  initial begin
    logic [15:0] res;
    logic        o;
    int          v;
    int          dones, last_done, nbad;
    logic        prev_busy;
    logic [15:0] alt_exp[2];

    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; bin_in = '0;

    vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[1]  = '{14'd0,     16'h0000, 1'b0};
    vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[3]  = '{14'd12000, 16'h9999, 1'b1};
    vecs[4]  = '{14'd5678,  16'h5678, 1'b0};
    vecs[5]  = '{14'd16383, 16'h9999, 1'b1};
    vecs[6]  = '{14'd10000, 16'h9999, 1'b1};
    vecs[7]  = '{14'd42,    16'h0042, 1'b0};
    vecs[8]  = '{14'd1,     16'h0001, 1'b0};
    vecs[9]  = '{14'd9,     16'h0009, 1'b0};
    vecs[10] = '{14'd10,    16'h0010, 1'b0};
    vecs[11] = '{14'd99,    16'h0099, 1'b0};
    vecs[12] = '{14'd100,   16'h0100, 1'b0};
    vecs[13] = '{14'd8050,  16'h8050, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_conv(vecs[i].bin, res, o);
      chk($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].bcd));
      chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
    end

    for (int i = 0; i < 20; i++) begin
      v = (i % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      run_conv(14'(v), res, o);
      chk($sformatf("rnd%0d_bcd_%0d", i, v), 32'(res), 32'(model_bcd(v)));
      chk($sformatf("rnd%0d_ovf_%0d", i, v), 32'(o), 32'(v > 9999));
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; bin_in = 14'd4321;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c < 40; c++) begin
      if (c == 5) begin start = 1'b1; bin_in = 14'd1111; end
      if (c == 6) start = 1'b0;
      if (done) begin
        dones++;
        chk("ignore_bcd", 32'(bcd_out), 32'h4321);
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 32'(dones), 32'd1);

    // reset mid-conversion aborts without a done pulse
    start = 1'b1; bin_in = 14'd8765;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk("abort_no_activity", 32'(dones), 32'd0);
    run_conv(14'd42, res, o);
    chk("after_abort_bcd", 32'(res), 32'h0042);
    chk("after_abort_ovf", 32'(o), 32'd0);

    // start held high: back-to-back conversions, alternating values
    alt_exp[0] = 16'h1234;
    alt_exp[1] = 16'h5678;
    @(negedge clk);
    start = 1'b1; bin_in = 14'd1234;
    prev_busy = 1'b0;
    dones = 0; last_done = -1; nbad = 0;
    for (int c = 0; c < 80 && dones < 4; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) bin_in = (bin_in == 14'd1234) ? 14'd5678 : 14'd1234;
      prev_busy = busy;
      if (done) begin
        chk($sformatf("b2b%0d_bcd", dones), 32'(bcd_out), 32'(alt_exp[dones % 2]));
        if (last_done >= 0) chk($sformatf("b2b%0d_period", dones), 32'(c - last_done), 32'd16);
        last_done = c;
        dones++;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(dones), 32'd4);
    repeat (20) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
